fp_norm_pack: RTL and testbench

- Stage directly downstream of the complex multiplier's second pipeline register. Consumes one registered floating-point product: mantissa Z1, biased exponent ZE1, sign ZS1 and exception flag E1.
- Normalises the mantissa with an iterative left-shift state machine and packs the result into IEEE-754 single-precision format.
- Subnormal results are flushed to zero.
- Valid/ready handshake on both sides, so it can feed the add/sub stage of the butterfly with backpressure.

---
 rtl/fp_pkg.sv | 9 +
 rtl/fp_pack.sv | 17 +
 rtl/fp_norm_pack.sv | 108 ++++++++++
 tb/tb_fp_norm_pack.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, state encoding and IEEE-754 single-precision constants
package fp_pkg;
   localparam int MAN_W = 24;
   localparam int EXP_W = 8;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [31:0] POS_INF = 32'h7F800000;
   localparam logic [31:0] NEG_INF = 32'hFF800000;
   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
endpackage

// File: rtl/fp_pack.sv
// fp_pack: combinational {sign, exp, frac} assembler with inf/zero override
module fp_pack #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                    sign_i,
   input  logic [EXP_W-1:0]        exp_i,
   input  logic [FRAC_W-1:0]       frac_i,
   input  logic                    inf_i,
   input  logic                    zero_i,
   output logic [EXP_W+FRAC_W:0]   y_o
);
   always_comb
      y_o = inf_i  ? {sign_i, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} :
            zero_i ? {sign_i, {(EXP_W+FRAC_W){1'b0}}} :
                     {sign_i, exp_i, frac_i};
endmodule

// File: rtl/fp_norm_pack.sv
// fp_norm_pack: iterative left-shift normaliser with flush-to-zero, packing to IEEE-754
module fp_norm_pack #(
   parameter int MAN_W = fp_pkg::MAN_W,
   parameter int EXP_W = fp_pkg::EXP_W,
   parameter int SH_W  = 5
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [MAN_W-1:0]       Z1,
   input  logic [EXP_W-1:0]       ZE1,
   input  logic                   ZS1,
   input  logic                   E1,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [EXP_W+MAN_W-1:0] Y,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   zero_o,
   output logic                   inf_o,
   output logic [SH_W-1:0]        shifts_o
);
   import fp_pkg::*;
   state_t state_q, state_d;
   logic [MAN_W-1:0] zr_q, zr_d;
   logic [EXP_W-1:0] er_q, er_d;
   logic sr_q, sr_d, zero_q, zero_d, inf_q, inf_d;
   logic [SH_W-1:0] cnt_q, cnt_d;
   logic [EXP_W+MAN_W-1:0] y_q, y_d, p_y;
   logic idle, p_sign, p_inf, p_zero;
   logic [EXP_W-1:0] p_exp;
   logic [MAN_W-2:0] p_frac;
   // The packer sees the raw inputs in IDLE and the working registers in NORM
   assign idle   = state_q == IDLE;
   assign p_sign = idle ? ZS1 : sr_q;
   assign p_exp  = idle ? ZE1 : er_q;
   assign p_frac = idle ? Z1[MAN_W-2:0] : zr_q[MAN_W-2:0];
   assign p_inf  = idle & E1;
   assign p_zero = idle ? (!E1 && (Z1 == '0 || ZE1 == '0)) : !zr_q[MAN_W-1];
   fp_pack #(.EXP_W(EXP_W), .FRAC_W(MAN_W-1)) u_pack (
      .sign_i(p_sign), .exp_i(p_exp), .frac_i(p_frac),
      .inf_i(p_inf), .zero_i(p_zero), .y_o(p_y)
   );
   always_comb begin
      state_d = state_q;
      zr_d    = zr_q;
      er_d    = er_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      zero_d  = zero_q;
      inf_d   = inf_q;
      case (state_q)
         IDLE: if (in_valid) begin
            zr_d  = Z1;
            er_d  = ZE1;
            sr_d  = ZS1;
            cnt_d = '0;
            if (E1 || Z1 == '0 || ZE1 == '0 || Z1[MAN_W-1]) begin
               state_d = DONE;
               y_d     = p_y;
               zero_d  = p_zero;
               inf_d   = E1;
            end else begin
               state_d = NORM;
            end
         end
         NORM: if (zr_q[MAN_W-1] || er_q[EXP_W-1:1] == '0) begin
            state_d = DONE;
            y_d     = p_y;
            zero_d  = !zr_q[MAN_W-1];
            inf_d   = 1'b0;
         end else begin
            zr_d  = zr_q << 1;
            er_d  = er_q - 1'b1;
            cnt_d = cnt_q + 1'b1;
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         zr_q    <= '0;
         er_q    <= '0;
         sr_q    <= 1'b0;
         cnt_q   <= '0;
         y_q     <= '0;
         zero_q  <= 1'b0;
         inf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         zr_q    <= zr_d;
         er_q    <= er_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         zero_q  <= zero_d;
         inf_q   <= inf_d;
      end
   end
   assign in_ready  = idle;
   assign out_valid = state_q == DONE;
   assign Y         = y_q;
   assign zero_o    = zero_q;
   assign inf_o     = inf_q;
   assign shifts_o  = cnt_q;
endmodule

// File: tb/tb_fp_norm_pack.sv
// tb_fp_norm_pack: directed vectors with hand-computed results for fp_norm_pack
module tb_fp_norm_pack;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [23:0] Z1 = '0;
   logic [7:0]  ZE1 = '0;
   logic        ZS1 = 1'b0, E1 = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid, zero_o, inf_o;
   logic [31:0] Y;
   logic [4:0]  shifts_o;
   int n_chk = 0, n_pass = 0, lat;
   logic flag;
   logic [31:0] y_hold;

   fp_norm_pack dut (
      .CLK(CLK), .RST(RST), .Z1(Z1), .ZE1(ZE1), .ZS1(ZS1), .E1(E1),
      .in_valid(in_valid), .in_ready(in_ready), .Y(Y), .out_valid(out_valid),
      .out_ready(out_ready), .zero_o(zero_o), .inf_o(inf_o), .shifts_o(shifts_o)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic issue(input logic [23:0] z, input logic [7:0] e, input logic s, input logic x);
      @(negedge CLK);
      Z1 = z; ZE1 = e; ZS1 = s; E1 = x; in_valid = 1'b1;
      @(posedge CLK);
      #1 in_valid = 1'b0;
   endtask

   // Counts cycles after the capture edge until out_valid; records whether in_ready stayed low
   task automatic wait_out(output int l, output logic busy);
      l = 0;
      busy = 1'b1;
      while (l < 40) begin
         @(negedge CLK);
         l++;
         if (in_ready) busy = 1'b0;
         if (out_valid) break;
      end
   endtask

   task automatic accept();
      out_ready = 1'b1;
      @(posedge CLK);
      #1 out_ready = 1'b0;
      @(negedge CLK);
      chk("ready_after_accept", 32'(in_ready), 32'd1);
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y", Y, 32'h0);
      chk("rst_flags", {29'd0, zero_o, inf_o, 1'b0}, 32'd0);
      chk("rst_shifts", 32'(shifts_o), 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      issue(24'h800000, 8'h7F, 1'b0, 1'b0);
      wait_out(lat, flag);
      chk("norm_lat", lat, 1);
      chk("norm_y", Y, 32'h3F800000);
      chk("norm_shifts", 32'(shifts_o), 32'd0);
      chk("norm_flags", {30'd0, zero_o, inf_o}, 32'd0);
      accept();

      issue(24'h200000, 8'h80, 1'b1, 1'b0);
      wait_out(lat, flag);
      chk("lz2_lat", lat, 4);
      chk("lz2_busy", 32'(flag), 32'd1);
      chk("lz2_y", Y, 32'hBF000000);
      chk("lz2_shifts", 32'(shifts_o), 32'd2);
      accept();

      issue(24'h000001, 8'h05, 1'b0, 1'b0);
      wait_out(lat, flag);
      chk("flush_lat", lat, 6);
      chk("flush_y", Y, 32'h0);
      chk("flush_zero", 32'(zero_o), 32'd1);
      chk("flush_shifts", 32'(shifts_o), 32'd4);
      accept();

      issue(24'hFFFFFF, 8'h10, 1'b1, 1'b1);
      wait_out(lat, flag);
      chk("inf_lat", lat, 1);
      chk("inf_y", Y, 32'hFF800000);
      chk("inf_flags", {30'd0, zero_o, inf_o}, 32'd1);
      accept();

      issue(24'h000000, 8'h7F, 1'b0, 1'b0);
      wait_out(lat, flag);
      chk("zman_lat", lat, 1);
      chk("zman_y", Y, 32'h0);
      chk("zman_zero", 32'(zero_o), 32'd1);
      accept();

      issue(24'h123456, 8'h00, 1'b1, 1'b0);
      wait_out(lat, flag);
      chk("zexp_y", Y, 32'h80000000);
      chk("zexp_zero", 32'(zero_o), 32'd1);
      accept();

      issue(24'h800000, 8'h80, 1'b0, 1'b0);
      wait_out(lat, flag);
      chk("bp_y", Y, 32'h40000000);
      y_hold = Y;
      flag = 1'b1;
      for (int i = 0; i < 5; i++) begin
         Z1 = 24'hC00000; ZE1 = 8'h81; ZS1 = 1'b0; E1 = 1'b0;
         in_valid = (i == 2);
         @(negedge CLK);
         if (!out_valid || in_ready || Y !== y_hold) flag = 1'b0;
      end
      in_valid = 1'b0;
      chk("bp_stable", 32'(flag), 32'd1);
      accept();
      chk("bp_no_capture", 32'(out_valid), 32'd0);
      issue(24'hC00000, 8'h81, 1'b0, 1'b0);
      wait_out(lat, flag);
      chk("bp_next_lat", lat, 1);
      chk("bp_next_y", Y, 32'h40C00000);
      accept();

      issue(24'h200000, 8'h80, 1'b1, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_y", Y, 32'h0);
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      RST = 1'b0;
      flag = 1'b0;
      repeat (8) begin
         @(negedge CLK);
         if (out_valid) flag = 1'b1;
      end
      chk("mrst_no_stale", 32'(flag), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
